uart_tx_sched: RTL and testbench

Byte scheduler that shares the single `uart_tx` serializer between two byte producers, such as the flash-command trace and the status/log path. Each producer has its own FIFO with a valid/ready port. A round-robin arbiter issues one byte at a time to `uart_tx`. The block pulses `iSEND`, waits for `oFINISH`, inserts an inter-frame gap, and runs a watchdog so that a missing finish pulse cannot stall the system.

---
 rtl/uart_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler that feeds one uart_tx serializer from two producer FIFOs.
// Each byte is loaded, pulsed out on oSEND, awaited with a watchdog, then followed by a gap.
module uart_tx_sched #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 131071
) (
  input  logic       clk_s,
  input  logic       rst_s,
  input  logic       iVALID_A,
  input  logic [7:0] iDATA_A,
  output logic       oREADY_A,
  input  logic       iVALID_B,
  input  logic [7:0] iDATA_B,
  output logic       oREADY_B,
  output logic       oSEND,
  output logic [7:0] oTXDATA,
  input  logic       iFINISH,
  input  logic       iCLR_ERR,
  output logic       oBUSY,
  output logic       oTO_ERR,
  output logic       oGRANT
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWait,
    StHold
  } state_e;

  // Index 0 is source A, index 1 is source B throughout.
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      ready;
  logic [1:0]      nonempty;
  logic [1:0][7:0] wdata;
  logic [1:0][7:0] head;

  assign wdata = {iDATA_B, iDATA_A};
  assign push  = {iVALID_B & ready[1], iVALID_A & ready[0]};

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk_s) begin
      if (rst_s) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push[s]) wptr_q <= wptr_q + 1'b1;
        if (pop[s])  rptr_q <= rptr_q + 1'b1;
        if (push[s] && !pop[s]) begin
          count_q <= count_q + 1'b1;
        end else if (pop[s] && !push[s]) begin
          count_q <= count_q - 1'b1;
        end
      end
    end

    // Storage carries no reset; stale entries are unreachable once the count is cleared.
    always_ff @(posedge clk_s) begin
      if (push[s]) mem_q[wptr_q] <= wdata[s];
    end

    assign ready[s]    = (count_q != CW'(DEPTH));
    assign nonempty[s] = (count_q != '0);
    assign head[s]     = mem_q[rptr_q];

    a_count_bound : assert property (@(posedge clk_s) disable iff (rst_s)
      count_q <= CW'(DEPTH));
    a_no_pop_empty : assert property (@(posedge clk_s) disable iff (rst_s)
      pop[s] |-> nonempty[s]);
  end

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          grant_q, grant_d;
  logic [7:0]    txdata_q, txdata_d;
  logic          err_q, err_d;
  logic          winner;

  // On a tie the source that did not go last wins; otherwise the only non-empty one.
  assign winner = (nonempty[0] && nonempty[1]) ? ~grant_q : nonempty[1];

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    grant_d  = grant_q;
    txdata_d = txdata_q;
    err_d    = err_q;
    pop      = '0;

    // Clear first so a watchdog set in the same cycle overrides it.
    if (iCLR_ERR) err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|nonempty) begin
          grant_d     = winner;
          txdata_d    = head[winner];
          pop[winner] = 1'b1;
          state_d     = StLoad;
        end
      end
      StLoad: state_d = StSend;
      StSend: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        if (iFINISH) begin
          timer_d = '0;
          state_d = StHold;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TW'(GAP - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      grant_q  <= 1'b1;
      txdata_q <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      grant_q  <= grant_d;
      txdata_q <= txdata_d;
      err_q    <= err_d;
    end
  end

  assign oSEND    = (state_q == StSend);
  assign oTXDATA  = txdata_q;
  assign oGRANT   = grant_q;
  assign oTO_ERR  = err_q;
  assign oBUSY    = (state_q != StIdle) || (|nonempty);
  assign oREADY_A = ready[0];
  assign oREADY_B = ready[1];

  a_send_single : assert property (@(posedge clk_s) disable iff (rst_s) oSEND |=> !oSEND);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus a randomized run, all checked against a
// timeline-level reference model (byte queues, grant bit and cycle timestamps).
module tb_uart_tx_sched;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned GAP     = 2;
  localparam int unsigned TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v_a = 1'b0, v_b = 1'b0, fin = 1'b0, clr = 1'b0;
  logic [7:0] d_a = 8'h00, d_b = 8'h00;
  logic       oREADY_A, oREADY_B, oSEND, oBUSY, oTO_ERR, oGRANT;
  logic [7:0] oTXDATA;

  always #5 clk = ~clk;

  uart_tx_sched #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk_s(clk), .rst_s(rst),
    .iVALID_A(v_a), .iDATA_A(d_a), .oREADY_A(oREADY_A),
    .iVALID_B(v_b), .iDATA_B(d_b), .oREADY_B(oREADY_B),
    .oSEND(oSEND), .oTXDATA(oTXDATA), .iFINISH(fin), .iCLR_ERR(clr),
    .oBUSY(oBUSY), .oTO_ERR(oTO_ERR), .oGRANT(oGRANT)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the cycle after edge number cyc is "cycle cyc".
  int         cyc = 0;
  logic [7:0] qa[$], qb[$];
  bit         m_inflight = 0, m_grant = 1, m_err = 0, m_send = 0, m_busy = 0;
  bit         m_ready_a = 1, m_ready_b = 1, m_acc_a = 0, m_acc_b = 0;
  logic [7:0] m_txdata = 8'h00;
  int         m_send_cyc = 0, m_wait_start = 0, m_idle_at = 0;
  logic [7:0] dut_bytes[$], mdl_bytes[$];
  logic       dut_grants[$];

  task automatic tick();
    bit idle_prev, src, set_err;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      qa.delete(); qb.delete();
      m_inflight = 0; m_grant = 1; m_err = 0; m_txdata = 8'h00;
      m_idle_at = cyc; m_acc_a = 0; m_acc_b = 0;
    end else begin
      m_acc_a   = v_a && (qa.size() < DEPTH);
      m_acc_b   = v_b && (qb.size() < DEPTH);
      idle_prev = !m_inflight && ((cyc - 1) >= m_idle_at);
      set_err   = 0;
      if (m_inflight && ((cyc - 1) >= m_wait_start)) begin
        if (fin) begin
          m_inflight = 0; m_idle_at = cyc + GAP;
        end else if ((cyc - 1) - m_wait_start == TIMEOUT - 1) begin
          set_err = 1; m_inflight = 0; m_idle_at = cyc + GAP;
        end
      end
      if (idle_prev && (qa.size() != 0 || qb.size() != 0)) begin
        src = (qa.size() != 0 && qb.size() != 0) ? !m_grant : (qb.size() != 0);
        m_grant      = src;
        m_txdata     = src ? qb.pop_front() : qa.pop_front();
        m_inflight   = 1;
        m_send_cyc   = cyc + 1;
        m_wait_start = cyc + 2;
      end
      if (set_err) m_err = 1;
      else if (clr) m_err = 0;
      if (m_acc_a) qa.push_back(d_a);
      if (m_acc_b) qb.push_back(d_b);
    end
    m_send    = m_inflight && (cyc == m_send_cyc);
    m_busy    = m_inflight || (cyc < m_idle_at) || qa.size() != 0 || qb.size() != 0;
    m_ready_a = qa.size() < DEPTH;
    m_ready_b = qb.size() < DEPTH;
    if (oSEND) begin
      dut_bytes.push_back(oTXDATA);
      dut_grants.push_back(oGRANT);
    end
    if (m_send) mdl_bytes.push_back(m_txdata);
  endtask

  task automatic do_reset();
    rst = 1; v_a = 0; v_b = 0; fin = 0; clr = 0;
    tick();
    rst = 0;
    dut_bytes.delete(); dut_grants.delete(); mdl_bytes.delete();
  endtask

  // Acts as the uart_tx: pulses finish dly cycles into each wait.
  task automatic run(input int n, input int dly);
    for (int i = 0; i < n; i++) begin
      fin = m_inflight && (cyc >= m_wait_start) && (cyc - m_wait_start == dly);
      tick();
    end
    fin = 0;
  endtask

  // Push one byte on A into an idle, empty scheduler and stop in its SEND cycle.
  task automatic launch(input logic [7:0] b);
    v_a = 1; d_a = b;
    tick();
    v_a = 0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (oSEND !== 1'b0) begin n_bad++; $display("FAIL reset_send got=%0b exp=0", oSEND); end
    n_cmp++; if (oTXDATA !== 8'h00) begin n_bad++; $display("FAIL reset_txdata got=%h exp=00", oTXDATA); end
    n_cmp++; if (oGRANT !== 1'b1) begin n_bad++; $display("FAIL reset_grant got=%0b exp=1", oGRANT); end
    n_cmp++; if (oTO_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%0b exp=0", oTO_ERR); end
    n_cmp++; if (oBUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", oBUSY); end
    n_cmp++; if ({oREADY_A, oREADY_B} !== 2'b11) begin
      n_bad++; $display("FAIL reset_ready got=%b exp=11", {oREADY_A, oREADY_B});
    end
  endtask

  task automatic test_single();
    do_reset();
    v_a = 1; d_a = 8'h5A;
    tick();
    v_a = 0;
    tick();
    n_cmp++; if (oSEND !== 1'b0) begin n_bad++; $display("FAIL single_load_send got=%0b exp=0", oSEND); end
    tick();
    n_cmp++; if (oSEND !== 1'b1) begin n_bad++; $display("FAIL single_send got=%0b exp=1", oSEND); end
    n_cmp++; if (oTXDATA !== 8'h5A) begin n_bad++; $display("FAIL single_data got=%h exp=5a", oTXDATA); end
    n_cmp++; if (oGRANT !== 1'b0) begin n_bad++; $display("FAIL single_grant got=%0b exp=0", oGRANT); end
    tick();
    fin = 1;
    tick();
    fin = 0;
    n_cmp++; if (oBUSY !== 1'b1) begin n_bad++; $display("FAIL single_hold_busy got=%0b exp=1", oBUSY); end
    for (int i = 1; i < GAP; i++) begin
      tick();
      n_cmp++; if (oBUSY !== 1'b1) begin n_bad++; $display("FAIL single_gap_busy got=%0b exp=1", oBUSY); end
    end
    tick();
    n_cmp++; if (oBUSY !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got=%0b exp=0", oBUSY); end
    n_cmp++; if (dut_bytes.size() !== 1) begin
      n_bad++; $display("FAIL single_pulses got=%0d exp=1", dut_bytes.size());
    end
  endtask

  task automatic test_alternation();
    logic [7:0] exp_b [5];
    logic       exp_g [5];
    logic [7:0] got_b;
    logic       got_g;
    exp_b = '{8'h01, 8'hA1, 8'h02, 8'hA2, 8'h03};
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    v_a = 1; d_a = 8'h01; v_b = 1; d_b = 8'hA1;
    tick();
    d_a = 8'h02; d_b = 8'hA2;
    tick();
    d_a = 8'h03; v_b = 0;
    tick();
    v_a = 0;
    run(80, 2);
    n_cmp++; if (dut_bytes.size() !== 5) begin
      n_bad++; $display("FAIL alt_count got=%0d exp=5", dut_bytes.size());
    end
    for (int i = 0; i < 5; i++) begin
      got_b = (i < dut_bytes.size()) ? dut_bytes[i] : 8'hxx;
      got_g = (i < dut_grants.size()) ? dut_grants[i] : 1'bx;
      n_cmp++; if (got_b !== exp_b[i]) begin
        n_bad++; $display("FAIL alt_byte%0d got=%h exp=%h", i, got_b, exp_b[i]);
      end
      n_cmp++; if (got_g !== exp_g[i]) begin
        n_bad++; $display("FAIL alt_grant%0d got=%0b exp=%0b", i, got_g, exp_g[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    logic [7:0] got_b, exp_byte;
    do_reset();
    v_b = 1; d_b = 8'hEE;
    tick();
    v_b = 0;
    for (int i = 0; i < 20; i++) begin
      v_a = 1; d_a = 8'(8'h10 + k);
      tick();
      if (m_acc_a) k++;
      n_cmp++; if (oREADY_A !== m_ready_a) begin
        n_bad++; $display("FAIL bp_ready_stall got=%0b exp=%0b", oREADY_A, m_ready_a);
      end
    end
    n_cmp++; if (k !== 8) begin n_bad++; $display("FAIL bp_accepted got=%0d exp=8", k); end
    n_cmp++; if (oREADY_A !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready got=%0b exp=0", oREADY_A); end
    fin = 1;
    tick();
    fin = 0;
    for (int i = 0; i < 20 && k < 9; i++) begin
      tick();
      if (m_acc_a) k++;
      n_cmp++; if (oREADY_A !== m_ready_a) begin
        n_bad++; $display("FAIL bp_ready_drain got=%0b exp=%0b", oREADY_A, m_ready_a);
      end
    end
    v_a = 0;
    n_cmp++; if (k !== 9) begin n_bad++; $display("FAIL bp_ninth got=%0d exp=9", k); end
    run(200, 1);
    n_cmp++; if (dut_bytes.size() !== 10) begin
      n_bad++; $display("FAIL bp_count got=%0d exp=10", dut_bytes.size());
    end
    for (int i = 0; i < 10; i++) begin
      exp_byte = (i == 0) ? 8'hEE : 8'(8'h10 + i - 1);
      got_b = (i < dut_bytes.size()) ? dut_bytes[i] : 8'hxx;
      n_cmp++; if (got_b !== exp_byte) begin
        n_bad++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got_b, exp_byte);
      end
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    launch(8'h77);
    n_cmp++; if (oSEND !== 1'b1) begin n_bad++; $display("FAIL wd_send got=%0b exp=1", oSEND); end
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      tick();
      if (k == TIMEOUT) begin
        n_cmp++; if (oTO_ERR !== 1'b0) begin n_bad++; $display("FAIL wd_early got=%0b exp=0", oTO_ERR); end
      end
    end
    n_cmp++; if (oTO_ERR !== 1'b1) begin n_bad++; $display("FAIL wd_fire got=%0b exp=1", oTO_ERR); end
    v_a = 1; d_a = 8'h78;
    tick();
    v_a = 0;
    run(30, 1);
    n_cmp++; if (dut_bytes.size() !== 2 || dut_bytes[dut_bytes.size()-1] !== 8'h78) begin
      n_bad++; $display("FAIL wd_next_send got_n=%0d exp_n=2", dut_bytes.size());
    end
    n_cmp++; if (oTO_ERR !== 1'b1) begin n_bad++; $display("FAIL wd_sticky got=%0b exp=1", oTO_ERR); end
    clr = 1;
    tick();
    clr = 0;
    n_cmp++; if (oTO_ERR !== 1'b0) begin n_bad++; $display("FAIL wd_clear got=%0b exp=0", oTO_ERR); end
    // Clear held through the timeout cycle: the set must still win.
    launch(8'h79);
    clr = 1;
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      tick();
      if (k == TIMEOUT) begin
        n_cmp++; if (oTO_ERR !== 1'b0) begin n_bad++; $display("FAIL wd_clr_early got=%0b exp=0", oTO_ERR); end
      end
    end
    clr = 0;
    n_cmp++; if (oTO_ERR !== 1'b1) begin n_bad++; $display("FAIL wd_set_wins got=%0b exp=1", oTO_ERR); end
  endtask

  task automatic test_tie();
    do_reset();
    launch(8'h33);
    for (int k = 1; k <= TIMEOUT; k++) tick();
    fin = 1;
    tick();
    fin = 0;
    n_cmp++; if (oTO_ERR !== 1'b0) begin n_bad++; $display("FAIL tie_err got=%0b exp=0", oTO_ERR); end
    run(10, 0);
    n_cmp++; if (oTO_ERR !== m_err) begin n_bad++; $display("FAIL tie_err_late got=%0b exp=%0b", oTO_ERR, m_err); end
    n_cmp++; if (oBUSY !== 1'b0) begin n_bad++; $display("FAIL tie_idle got=%0b exp=0", oBUSY); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    v_a = 1; d_a = 8'hC1;
    tick();
    d_a = 8'hC2;
    tick();
    v_a = 0;
    tick();
    n_cmp++; if (oSEND !== 1'b1) begin n_bad++; $display("FAIL b2b_first got=%0b exp=1", oSEND); end
    tick();
    fin = 1;
    tick();
    fin = 0;
    n = 1;
    while (!oSEND && n < 20) begin
      tick();
      n++;
    end
    n_cmp++; if (n !== GAP + 3) begin n_bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", n, GAP + 3); end
    n_cmp++; if (oTXDATA !== 8'hC2) begin n_bad++; $display("FAIL b2b_data got=%h exp=c2", oTXDATA); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    v_a = 1; d_a = 8'hA0; v_b = 1; d_b = 8'hB0;
    tick();
    d_a = 8'hA1; d_b = 8'hB1;
    tick();
    v_a = 0; v_b = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    dut_bytes.delete();
    n_cmp++; if (oSEND !== 1'b0) begin n_bad++; $display("FAIL mid_send got=%0b exp=0", oSEND); end
    n_cmp++; if (oTXDATA !== 8'h00) begin n_bad++; $display("FAIL mid_txdata got=%h exp=00", oTXDATA); end
    n_cmp++; if (oGRANT !== 1'b1) begin n_bad++; $display("FAIL mid_grant got=%0b exp=1", oGRANT); end
    n_cmp++; if (oBUSY !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%0b exp=0", oBUSY); end
    n_cmp++; if ({oREADY_A, oREADY_B} !== 2'b11) begin
      n_bad++; $display("FAIL mid_ready got=%b exp=11", {oREADY_A, oREADY_B});
    end
    fin = 1;
    tick();
    fin = 0;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (dut_bytes.size() !== 0) begin
      n_bad++; $display("FAIL mid_no_send got=%0d exp=0", dut_bytes.size());
    end
    n_cmp++; if (oBUSY !== 1'b0 || oTO_ERR !== 1'b0) begin
      n_bad++; $display("FAIL mid_quiet got=%b exp=00", {oBUSY, oTO_ERR});
    end
  endtask

  task automatic test_random();
    int dly = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!v_a && $urandom_range(0, 3) == 0) begin v_a = 1; d_a = 8'($urandom); end
      if (!v_b && $urandom_range(0, 4) == 0) begin v_b = 1; d_b = 8'($urandom); end
      if (m_inflight && cyc == m_wait_start) dly = $urandom_range(0, TIMEOUT + 5);
      fin = (m_inflight && cyc >= m_wait_start && cyc - m_wait_start == dly)
            || ($urandom_range(0, 49) == 0);
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 999) == 0);
      tick();
      if (m_acc_a) v_a = 0;
      if (m_acc_b) v_b = 0;
      n_cmp++; if (oSEND !== m_send) begin n_bad++; $display("FAIL rnd_send c=%0d got=%0b exp=%0b", cyc, oSEND, m_send); end
      n_cmp++; if (oTXDATA !== m_txdata) begin n_bad++; $display("FAIL rnd_txdata c=%0d got=%h exp=%h", cyc, oTXDATA, m_txdata); end
      n_cmp++; if (oGRANT !== m_grant) begin n_bad++; $display("FAIL rnd_grant c=%0d got=%0b exp=%0b", cyc, oGRANT, m_grant); end
      n_cmp++; if (oTO_ERR !== m_err) begin n_bad++; $display("FAIL rnd_err c=%0d got=%0b exp=%0b", cyc, oTO_ERR, m_err); end
      n_cmp++; if (oBUSY !== m_busy) begin n_bad++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", cyc, oBUSY, m_busy); end
      n_cmp++; if ({oREADY_A, oREADY_B} !== {m_ready_a, m_ready_b}) begin
        n_bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", cyc, {oREADY_A, oREADY_B}, {m_ready_a, m_ready_b});
      end
    end
    rst = 0; clr = 0; fin = 0;
    n_cmp++; if (dut_bytes.size() !== mdl_bytes.size()) begin
      n_bad++; $display("FAIL rnd_total got=%0d exp=%0d", dut_bytes.size(), mdl_bytes.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternation();
    test_backpressure();
    test_watchdog();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
